mem_access_stage: RTL
=====================

Name: mem_access_stage

Overview:
- Memory stage directly downstream of the execute stage; consumes the ALU result, store data, zero flag and branch target.
- Holds the EX/MEM pipeline register and resolves branches (pc_src).
- Performs LDUR/STUR through a request/grant/rvalid handshake to data memory, then hands the result to writeback.
- Stalls execute while a memory access is outstanding.

Parameters:
- WORD, 64, datapath width; must equal the `WORD` definition.
- ADDR_LSB, 3, number of address LSBs that must be zero for an aligned access (log2(WORD/8)).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ex_valid  in  1  execute presents a valid instruction.
- ex_ready  out  1  stage can accept; high in IDLE or DONE.
- alu_result  in  WORD  address for loads/stores; result for ALU ops.
- store_data  in  WORD  read_data2 from execute.
- zero  in  1  ALU zero flag.
- branch_target  in  WORD  computed branch destination.
- mem_read, mem_write, mem_to_reg, reg_write, branch, uncond_branch  in  1 each  control bits from decode.
- rd  in  5  destination register.
- pc_src  out  1  one-cycle pulse: take branch.
- pc_target  out  WORD  registered branch_target; valid when pc_src=1.
- dmem_req  out  1  memory request.
- dmem_we  out  1  1 = store.
- dmem_addr  out  WORD  request address.
- dmem_wdata  out  WORD  store data.
- dmem_gnt  in  1  request accepted this cycle.
- dmem_rvalid  in  1  load data valid.
- dmem_rdata  in  WORD  load data.
- wb_valid  out  1  one-cycle pulse: result to writeback.
- wb_data  out  WORD  load data if mem_to_reg, else alu_result.
- wb_rd  out  5  destination register.
- wb_reg_write  out  1  write enable; forced 0 on misaligned access.
- misalign_err  out  1  one-cycle pulse on misaligned load/store.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All outputs 0: pc_src, pc_target, dmem_*, wb_*, misalign_err. Reset mid-access abandons the access; a late dmem_rvalid after reset is ignored in IDLE.
- Capture condition: ex_valid & ex_ready. On capture, all inputs are registered into the EX/MEM register.
- pc_src = uncond_branch | (branch & zero), registered. It pulses in the cycle after capture, independent of memory ops. pc_target is updated on every capture.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE on capture:
  - Memory op (mem_read|mem_write) with alu_result[ADDR_LSB-1:0]≠0: go to DONE with wb_reg_write=0 and misalign_err=1 in DONE. No dmem request is issued.
  - Aligned memory op: go to REQ.
  - Otherwise: go to DONE with wb_data=alu_result.
- REQ:
  - dmem_req=1; dmem_addr, dmem_wdata and dmem_we (=mem_write) are held stable until dmem_gnt.
  - On gnt: a store goes to DONE; a load goes to WAIT.
  - dmem_rvalid in the same cycle as gnt is accepted: the load goes straight to DONE with the data latched.
- WAIT: on dmem_rvalid, latch dmem_rdata into wb_data and go to DONE.
- DONE:
  - wb_valid=1 for exactly one cycle; stores give wb_reg_write=0.
  - ex_ready=1: a capture in DONE is handled as from IDLE, otherwise go to IDLE. This gives one ALU op per cycle back-to-back.
- mem_read and mem_write both set: treated as a load, and dmem_we=0.
- ex_ready is a combinational function of state only.
- Widths: addresses and data are WORD bits; no arithmetic in this stage.

Decomposition:
- Shared package/definitions: `WORD`, FSM state encoding, and a control-bundle typedef (mem_read … uncond_branch, rd) reused by the ID/EX and MEM/WB registers.
- One natural sub-module, ex_mem_reg: the enable-gated, async-reset pipeline register for data and control.

Test Plan:
- ALU op: alu_result=0x2A, reg_write=1, rd=5, ex_valid=1 → wb_valid 1 cycle later, wb_data=0x2A, wb_rd=5, wb_reg_write=1, no dmem_req.
- Load: addr=0x100, gnt after 2 cycles, rvalid 3 cycles after gnt with rdata=0xDEAD → wb_data=0xDEAD; ex_ready low from capture until DONE.
- Store: addr=0x18, store_data=0x55, gnt held low for 4 cycles → dmem_req/addr/wdata stable throughout; then wb_valid with wb_reg_write=0.
- Branch: branch=1, zero=1, branch_target=0x400 → pc_src=1 for one cycle, pc_target=0x400. Repeat with zero=0 → pc_src stays 0.
- Misaligned: mem_read=1, addr=0x104 → misalign_err pulse, no dmem_req, wb_reg_write=0.
- Reset while in WAIT, then rvalid arrives → all outputs 0, state IDLE, no wb_valid.

Source files
------------

// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the memory-access stage: datapath width, FSM encoding
// and the control bundle carried through the EX/MEM and MEM/WB registers.
`ifndef WORD
`define WORD 64
`endif

package mem_access_stage_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       branch;
        logic       uncond_branch;
        logic [4:0] rd;
    } ctrl_t;

    // mem_read wins when both mem_read and mem_write are set
    function automatic logic is_store(input ctrl_t c);
        return c.mem_write & ~c.mem_read;
    endfunction

endpackage

// File: rtl/mem_access_stage_ex_mem_reg.sv
// EX/MEM pipeline register: enable-gated, asynchronously cleared copy of the
// execute-stage data and control bundle.
module ex_mem_reg
    import mem_access_stage_pkg::*;
#(
    parameter int WORD = `WORD
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [WORD-1:0] alu_result,
    input  logic [WORD-1:0] store_data,
    input  logic [WORD-1:0] branch_target,
    input  ctrl_t           ctrl,
    output logic [WORD-1:0] alu_q,
    output logic [WORD-1:0] store_q,
    output logic [WORD-1:0] target_q,
    output ctrl_t           ctrl_q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_q    <= '0;
            store_q  <= '0;
            target_q <= '0;
            ctrl_q   <= '0;
        end else if (en) begin
            alu_q    <= alu_result;
            store_q  <= store_data;
            target_q <= branch_target;
            ctrl_q   <= ctrl;
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// Memory stage: EX/MEM register, branch resolution and a req/gnt/rvalid data
// memory access, producing a one-cycle writeback pulse per instruction.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int WORD     = `WORD,
    parameter int ADDR_LSB = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic [WORD-1:0] alu_result,
    input  logic [WORD-1:0] store_data,
    input  logic            zero,
    input  logic [WORD-1:0] branch_target,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic            mem_to_reg,
    input  logic            reg_write,
    input  logic            branch,
    input  logic            uncond_branch,
    input  logic [4:0]      rd,
    output logic            pc_src,
    output logic [WORD-1:0] pc_target,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [WORD-1:0] dmem_addr,
    output logic [WORD-1:0] dmem_wdata,
    input  logic            dmem_gnt,
    input  logic            dmem_rvalid,
    input  logic [WORD-1:0] dmem_rdata,
    output logic            wb_valid,
    output logic [WORD-1:0] wb_data,
    output logic [4:0]      wb_rd,
    output logic            wb_reg_write,
    output logic            misalign_err,
    output state_t          dbg_state
);

    state_t          state, state_nx;
    ctrl_t           ctrl_in, ctrl_q;
    logic [WORD-1:0] alu_q, store_q, target_q;
    logic [WORD-1:0] wb_data_q;
    logic            pc_src_q, misalign_q;
    logic            capture, in_mem, in_misalign, rdata_take;

    assign ctrl_in     = '{mem_read, mem_write, mem_to_reg, reg_write, branch, uncond_branch, rd};
    assign ex_ready    = (state == IDLE) || (state == DONE);
    assign capture     = ex_valid & ex_ready;
    assign in_mem      = mem_read | mem_write;
    assign in_misalign = in_mem & (alu_result[ADDR_LSB-1:0] != '0);
    // Load data is taken in WAIT, or in REQ when rvalid arrives together with gnt
    assign rdata_take  = dmem_rvalid &
                         (((state == REQ) && dmem_gnt && !is_store(ctrl_q)) || (state == WAIT));

    ex_mem_reg #(.WORD(WORD)) u_ex_mem_reg (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (capture),
        .alu_result    (alu_result),
        .store_data    (store_data),
        .branch_target (branch_target),
        .ctrl          (ctrl_in),
        .alu_q         (alu_q),
        .store_q       (store_q),
        .target_q      (target_q),
        .ctrl_q        (ctrl_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc_src_q   <= 1'b0;
            misalign_q <= 1'b0;
            wb_data_q  <= '0;
        end else begin
            state    <= state_nx;
            pc_src_q <= capture & (uncond_branch | (branch & zero));
            if (capture) begin
                misalign_q <= in_misalign;
                wb_data_q  <= alu_result;
            end else if (rdata_take) begin
                wb_data_q  <= dmem_rdata;
            end
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE, DONE: begin
                if (!ex_valid)        state_nx = IDLE;
                else if (in_misalign) state_nx = DONE;
                else if (in_mem)      state_nx = REQ;
                else                  state_nx = DONE;
            end
            REQ: begin
                if (dmem_gnt) begin
                    if (is_store(ctrl_q) || dmem_rvalid) state_nx = DONE;
                    else                                 state_nx = WAIT;
                end
            end
            WAIT: begin
                if (dmem_rvalid) state_nx = DONE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Request fields come from the EX/MEM register, so they hold until gnt
    assign dmem_req     = (state == REQ);
    assign dmem_we      = dmem_req & is_store(ctrl_q);
    assign dmem_addr    = dmem_req ? alu_q   : '0;
    assign dmem_wdata   = dmem_req ? store_q : '0;

    assign pc_src       = pc_src_q;
    assign pc_target    = target_q;
    assign wb_valid     = (state == DONE);
    assign wb_data      = wb_data_q;
    assign wb_rd        = ctrl_q.rd;
    assign wb_reg_write = wb_valid & ctrl_q.reg_write & ~misalign_q & ~is_store(ctrl_q);
    assign misalign_err = wb_valid & misalign_q;
    assign dbg_state    = state;

endmodule
